// File: rtl/otter_fetch_pkg.sv
// Shared types and constants for the OTTER instruction fetch stage.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package otter_fetch_pkg;

  localparam int unsigned XLEN = 32;

  // Canonical RV32I NOP: addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

endpackage : otter_fetch_pkg

// File: rtl/otter_pc_reg.sv
// Program counter register: reset load, +4 increment, masked redirect load.
// Latency: 1 cycle from load/increment enable to updated pc.
// Backpressure: none; redirect load wins over increment in the same cycle.
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset (loads RESET_PC)
//   inc_en        : advance pc by 4 (wraps modulo 2^32)
//   load_en       : load load_pc with bits [1:0] cleared
//   load_pc       : redirect target
//   pc            : current program counter
module otter_pc_reg
  import otter_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            inc_en,
  input  logic            load_en,
  input  logic [XLEN-1:0] load_pc,
  output logic [XLEN-1:0] pc
);

  localparam logic [XLEN-1:0] WORD_MASK = ~32'h0000_0003;

  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_en) begin
      pc_d = load_pc & WORD_MASK;
    end else if (inc_en) begin
      pc_d = pc_q + 32'd4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc = pc_q;

endmodule : otter_pc_reg

// File: rtl/otter_fetch_unit.sv
// OTTER fetch stage: owns the PC, issues word reads, registers IR for decode.
// Latency: ack -> rvalid -> ir_valid; best case ir_valid 2 cycles after ack.
// Backpressure: holds IR stable until ir_ready; one request outstanding max.
//
// Ports:
//   CLK, RST                          : clock, synchronous active-high reset
//   imem_req/addr, imem_ack           : request channel (addr == PC)
//   imem_rvalid/rdata                 : response channel, one per accepted req
//   redirect_valid/pc                 : PC change from execute, highest priority
//   IR, ir_pc, ir_pc_plus4, ir_valid  : registered instruction to decode
//   ir_ready                          : decode consumes IR
module otter_fetch_unit
  import otter_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            CLK,
  input  logic            RST,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] IR,
  output logic [XLEN-1:0] ir_pc,
  output logic [XLEN-1:0] ir_pc_plus4,
  output logic            ir_valid,
  input  logic            ir_ready
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] ir_q, ir_d;
  logic [XLEN-1:0] ir_pc_q, ir_pc_d;
  logic [XLEN-1:0] ir_pc_plus4_q, ir_pc_plus4_d;
  logic            ir_valid_q, ir_valid_d;
  logic            pc_inc;
  logic [XLEN-1:0] pc;

  otter_pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (CLK),
    .rst     (RST),
    .inc_en  (pc_inc),
    .load_en (redirect_valid),
    .load_pc (redirect_pc),
    .pc      (pc)
  );

  always_comb begin
    state_d       = state_q;
    ir_d          = ir_q;
    ir_pc_d       = ir_pc_q;
    ir_pc_plus4_d = ir_pc_plus4_q;
    ir_valid_d    = ir_valid_q;
    pc_inc        = 1'b0;

    if (redirect_valid) begin
      // A redirect drops whatever is held; if a response is still owed after
      // this edge we must swallow it in DRAIN before issuing the new PC.
      ir_valid_d = 1'b0;
      unique case (state_q)
        REQ:     state_d = imem_ack    ? DRAIN : REQ;
        WAIT:    state_d = imem_rvalid ? REQ   : DRAIN;
        HOLD:    state_d = REQ;
        DRAIN:   state_d = imem_rvalid ? REQ   : DRAIN;
        default: state_d = REQ;
      endcase
    end else begin
      unique case (state_q)
        REQ: begin
          if (imem_ack) state_d = WAIT;
        end
        WAIT: begin
          if (imem_rvalid) begin
            ir_d          = imem_rdata;
            ir_pc_d       = pc;
            ir_pc_plus4_d = pc + 32'd4;
            ir_valid_d    = 1'b1;
            state_d       = HOLD;
          end
        end
        HOLD: begin
          if (ir_ready) begin
            pc_inc     = 1'b1;
            ir_valid_d = 1'b0;
            state_d    = REQ;
          end
        end
        DRAIN: begin
          if (imem_rvalid) state_d = REQ;
        end
        default: state_d = REQ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q       <= REQ;
      ir_q          <= NOP_INSTR;
      ir_pc_q       <= RESET_PC;
      ir_pc_plus4_q <= RESET_PC + 32'd4;
      ir_valid_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      ir_q          <= ir_d;
      ir_pc_q       <= ir_pc_d;
      ir_pc_plus4_q <= ir_pc_plus4_d;
      ir_valid_q    <= ir_valid_d;
    end
  end

  // Request side decodes from state and PC only: no input-to-output path.
  assign imem_req    = (state_q == REQ);
  assign imem_addr   = pc;
  assign IR          = ir_q;
  assign ir_pc       = ir_pc_q;
  assign ir_pc_plus4 = ir_pc_plus4_q;
  assign ir_valid    = ir_valid_q;

endmodule : otter_fetch_unit
